// File: rtl/fifo_read_drain_if.sv
// Stream and FIFO-read bundle for fifo_read_drain.
// The master modport is the drain itself: it issues rd_en towards the FIFO,
// takes buf_out/buf_empty back, and drives the valid/ready output stream.
// The slave modport is the environment side (FIFO plus stream consumer).
interface fifo_read_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rd_en;
    logic                  buf_empty;
    logic [DATA_WIDTH-1:0] buf_out;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output rd_en,
        input  buf_empty,
        input  buf_out,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  rd_en,
        output buf_empty,
        output buf_out,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_read_drain.sv
// fifo_read_drain: read-side consumer of the dual-clock FIFO, in the rd_clk domain.
// Issues rd_en, absorbs the FIFO's one-cycle registered read latency with a
// 2-entry skid buffer, and presents the words as a bubble-free valid/ready stream.
// A read is only issued when the buffer is guaranteed room for it, counting the
// word already in flight, so backpressure never drops or duplicates a word.
// Optional feature: define FIFO_DRAIN_CNT_EN to add the saturating word_cnt output.
module fifo_read_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Clear_in,
    fifo_read_drain_if.master     bus
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

    logic                  run_reg;
    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;
    logic                  inflight_reg;
    logic [DATA_WIDTH-1:0] slot0_reg;
    logic [DATA_WIDTH-1:0] slot0_next;
    logic [DATA_WIDTH-1:0] slot1_reg;
    logic [DATA_WIDTH-1:0] slot1_next;
    logic                  pop;
    logic                  issue;
    logic [1:0]            fill;
    logic [1:0]            cap_idx;

    // Stream side: head of the skid buffer is always what is presented.
    assign bus.m_valid = (occ_reg != 2'd0);
    assign bus.m_data  = slot0_reg;
    assign pop         = bus.m_valid & bus.m_ready;

    // Entries that will be held after this edge, including the word on buf_out.
    // occ + inflight never exceeds 2, and pop implies occ >= 1, so no wrap.
    assign fill    = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
    // Slot that the in-flight word lands in once the popped head is removed.
    assign cap_idx = occ_reg - {1'b0, pop};

    // Only read when the result is certain to fit next to whatever is kept.
    assign issue     = run_reg & ~Clear_in & ~bus.buf_empty & (fill < 2'd2);
    assign bus.rd_en = issue;

    // Next buffer contents: shift on pop, then drop the arriving word into the
    // first free slot; a flush empties the buffer and discards that word.
    always_comb begin
        slot0_next = slot0_reg;
        slot1_next = slot1_reg;
        occ_next   = fill;
        if (pop && (occ_reg == 2'd2)) begin
            slot0_next = slot1_reg;
        end
        if (inflight_reg) begin
            if (cap_idx == 2'd0) begin
                slot0_next = bus.buf_out;
            end else begin
                slot1_next = bus.buf_out;
            end
        end
        if (Clear_in) begin
            occ_next = 2'd0;
        end
    end

    // State registers; run_reg holds off the first read until one edge after reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            run_reg      <= 1'b0;
            occ_reg      <= 2'd0;
            inflight_reg <= 1'b0;
            slot0_reg    <= '0;
            slot1_reg    <= '0;
        end else begin
            run_reg      <= 1'b1;
            occ_reg      <= occ_next;
            // issue is forced low during a flush, so nothing stays in flight.
            inflight_reg <= issue;
            slot0_reg    <= slot0_next;
            slot1_reg    <= slot1_next;
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_reg;

    // Saturating count of words handed to the consumer; a flush restarts it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_reg <= '0;
        end else if (Clear_in) begin
            cnt_reg <= '0;
        end else if (pop && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign word_cnt = cnt_reg;
`endif

endmodule
